// File: rtl/serial_adder_core_if.sv
// Request/response bundle between a requester and serial_adder_core.
// The requester drives operands and control; the core returns status and result.
interface serial_adder_core_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, mode, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, mode, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_core.sv
// Digit-serial adder/subtractor/accumulator: DIGIT bits per enabled clock, LSB first,
// with a registered carry between digits. One result every WIDTH/DIGIT enabled cycles.
module serial_adder_core #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    serial_adder_core_if.slave   bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;

    generate
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_adder_core: WIDTH must be an integer multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   part_q, part_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc_op_q, acc_op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    // One digit of the ripple: DIGIT result bits plus carry-out in the top bit.
    logic [DIGIT:0]       digit_sum;
    logic                 carry_into_msb;
    logic [WIDTH+DIGIT-1:0] part_cat;
    logic [WIDTH-1:0]     part_next;

    assign digit_sum = {1'b0, x_q[DIGIT-1:0]}
                     + {1'b0, y_q[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry_q};

    // Sum bit = x ^ y ^ carry-in, so the carry into the digit's top bit is recoverable.
    // On the final step that top bit is the word MSB, which is what ovf needs.
    assign carry_into_msb = x_q[DIGIT-1] ^ y_q[DIGIT-1] ^ digit_sum[DIGIT-1];

    assign part_cat  = {digit_sum[DIGIT-1:0], part_q};
    assign part_next = part_cat[WIDTH+DIGIT-1:DIGIT];

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path can leave one unassigned
        // and infer a latch.
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        part_d   = part_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        acc_op_d = acc_op_q;
        acc_d    = acc_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        if (ena) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (bus.start) begin
                        cnt_d    = '0;
                        part_d   = '0;
                        acc_op_d = (bus.mode == MODE_ACC);
                        state_d  = S_RUN;
                        case (bus.mode)
                            MODE_ADD: begin
                                x_d     = bus.a;
                                y_d     = bus.b;
                                carry_d = bus.cin;
                            end
                            MODE_SUB: begin
                                x_d     = bus.a;
                                y_d     = ~bus.b;
                                carry_d = 1'b1;
                            end
                            MODE_ACC: begin
                                x_d     = acc_q;
                                y_d     = bus.a;
                                carry_d = bus.cin;
                            end
                            default: begin
                                sum_d   = '0;
                                acc_d   = '0;
                                cout_d  = 1'b0;
                                ovf_d   = 1'b0;
                                state_d = S_DONE;
                            end
                        endcase
                    end
                end

                S_RUN: begin
                    x_d     = x_q >> DIGIT;
                    y_d     = y_q >> DIGIT;
                    part_d  = part_next;
                    carry_d = digit_sum[DIGIT];
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(STEPS - 1)) begin
                        sum_d   = part_next;
                        cout_d  = digit_sum[DIGIT];
                        ovf_d   = carry_into_msb ^ digit_sum[DIGIT];
                        if (acc_op_q) begin
                            acc_d = part_next;
                        end
                        state_d = S_DONE;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    // Shift registers and carry are reset too, so an aborted run leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            part_q   <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            acc_op_q <= 1'b0;
            acc_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of the others.
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            part_q   <= part_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            acc_op_q <= acc_op_d;
            acc_q    <= acc_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_core.sv
// Directed bench for serial_adder_core: a vector table for the 8-bit/2-bit build,
// hand sequences for handshake, enable and reset corners, and a 1-bit/1-bit sweep.
module tb_serial_adder_core;
    localparam int STEPS8 = 4;
    localparam logic [1:0] M_ADD = 2'b00;
    localparam logic [1:0] M_SUB = 2'b01;
    localparam logic [1:0] M_ACC = 2'b10;
    localparam logic [1:0] M_CLR = 2'b11;

    logic clk;
    logic rst_n;
    logic ena;

    int errors = 0;
    int checks = 0;
    logic [7:0] prev_sum = 8'h00;

    serial_adder_core_if #(.WIDTH(8)) ifc ();
    serial_adder_core_if #(.WIDTH(1)) ifc1 ();

    serial_adder_core #(.WIDTH(8), .DIGIT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (ifc)
    );

    serial_adder_core #(.WIDTH(1), .DIGIT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (ifc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one operation, scramble the inputs after the start edge, wait for done.
    task automatic run_op(input vec_t v, input string tag);
        int n;
        int busy_n;
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.mode  = v.mode;
        ifc.a     = v.a;
        ifc.b     = v.b;
        ifc.cin   = v.cin;
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.mode  = M_CLR;
        ifc.a     = ~v.a;
        ifc.b     = ~v.b;
        ifc.cin   = ~v.cin;
        if (v.mode != M_CLR) check({tag, " sum held in RUN"}, ifc.sum, prev_sum);
        busy_n = 0;
        n = 0;
        while (ifc.done !== 1'b1 && n < 20) begin
            if (ifc.busy === 1'b1) busy_n++;
            @(negedge clk);
            n++;
        end
        check({tag, " done"}, ifc.done, 1);
        check({tag, " busy cycles"}, busy_n, (v.mode == M_CLR) ? 0 : STEPS8);
        check({tag, " sum"}, ifc.sum, v.sum);
        check({tag, " cout"}, ifc.cout, v.cout);
        check({tag, " ovf"}, ifc.ovf, v.ovf);
        prev_sum = v.sum;
        @(negedge clk);
        check({tag, " done pulse ends"}, ifc.done, 0);
    endtask

    // Wait (bounded) for done on the 8-bit DUT; returns cycles waited.
    task automatic wait_done(output int n);
        n = 0;
        while (ifc.done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int cyc;
        int done_cnt;
        vec_t v;

        ifc.start = 1'b0; ifc.mode = M_ADD; ifc.a = '0; ifc.b = '0; ifc.cin = 1'b0;
        ifc1.start = 1'b0; ifc1.mode = M_ADD; ifc1.a = '0; ifc1.b = '0; ifc1.cin = 1'b0;
        ena = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        //           mode   a      b      cin   sum    cout  ovf
        vecs.push_back('{M_ADD, 8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 1'b1});
        vecs.push_back('{M_SUB, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0});
        vecs.push_back('{M_SUB, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1});
        vecs.push_back('{M_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{M_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{M_CLR, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{M_ACC, 8'hFF, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{M_ADD, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0});
        vecs.push_back('{M_ACC, 8'h02, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0});
        vecs.push_back('{M_ACC, 8'h10, 8'hFF, 1'b1, 8'h12, 1'b0, 1'b0});
        vecs.push_back('{M_SUB, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{M_ACC, 8'h80, 8'h00, 1'b0, 8'h92, 1'b0, 1'b0});

        @(negedge clk);
        check("reset busy", ifc.busy, 0);
        check("reset done", ifc.done, 0);
        check("reset sum", ifc.sum, 0);
        check("reset cout", ifc.cout, 0);
        check("reset ovf", ifc.ovf, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // start pulsed mid-RUN is ignored
        @(negedge clk);
        ifc.start = 1'b1; ifc.mode = M_ADD; ifc.a = 8'h11; ifc.b = 8'h22; ifc.cin = 1'b0;
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        ifc.start = 1'b1; ifc.a = 8'hFF; ifc.b = 8'hFF;
        @(negedge clk);
        ifc.start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (ifc.done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("midrun start done count", done_cnt, 1);
        check("midrun start sum", ifc.sum, 8'h33);

        // back-to-back: start in the DONE cycle
        @(negedge clk);
        ifc.start = 1'b1; ifc.mode = M_ADD; ifc.a = 8'h01; ifc.b = 8'h02; ifc.cin = 1'b0;
        @(negedge clk);
        ifc.start = 1'b0;
        wait_done(n);
        check("b2b first done", ifc.done, 1);
        check("b2b first sum", ifc.sum, 8'h03);
        ifc.start = 1'b1; ifc.mode = M_SUB; ifc.a = 8'h09; ifc.b = 8'h03;
        @(negedge clk);
        ifc.start = 1'b0;
        check("b2b busy next cycle", ifc.busy, 1);
        check("b2b done dropped", ifc.done, 0);
        wait_done(n);
        check("b2b second sum", ifc.sum, 8'h06);
        check("b2b second cout", ifc.cout, 1);
        @(negedge clk);

        // ena low for 3 cycles mid-RUN
        @(negedge clk);
        ifc.start = 1'b1; ifc.mode = M_ADD; ifc.a = 8'h5A; ifc.b = 8'h33; ifc.cin = 1'b1;
        cyc = 0;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (ifc.done === 1'b1) break;
            if (cyc == 1) ifc.start = 1'b0;
            if (cyc == 2) ena = 1'b0;
            if (cyc == 4) begin
                check("ena low busy held", ifc.busy, 1);
                check("ena low sum held", ifc.sum, 8'h06);
            end
            if (cyc == 5) ena = 1'b1;
        end
        check("ena stall latency", cyc, 8);
        check("ena stall sum", ifc.sum, 8'h8E);
        ena = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("done stretched by ena", ifc.done, 1);
        ena = 1'b1;
        @(negedge clk);
        check("done after stretch", ifc.done, 0);

        // reset mid-RUN
        @(negedge clk);
        ifc.start = 1'b1; ifc.mode = M_ADD; ifc.a = 8'h40; ifc.b = 8'h40; ifc.cin = 1'b0;
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun reset busy", ifc.busy, 0);
        check("midrun reset done", ifc.done, 0);
        check("midrun reset sum", ifc.sum, 0);
        check("midrun reset cout", ifc.cout, 0);
        check("midrun reset ovf", ifc.ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifc.done === 1'b1) done_cnt++;
        end
        check("no done after reset", done_cnt, 0);
        prev_sum = 8'h00;
        v = '{M_ADD, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        run_op(v, "post reset add");
        v = '{M_ACC, 8'h05, 8'h00, 1'b0, 8'h05, 1'b0, 1'b0};
        run_op(v, "post reset acc");

        // WIDTH=1, DIGIT=1 sweep
        for (int i = 0; i < 8; i++) begin
            int bn;
            int w;
            logic [1:0] exp2;
            exp2 = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
            @(negedge clk);
            ifc1.start = 1'b1; ifc1.mode = M_ADD;
            ifc1.a = i[2]; ifc1.b = i[1]; ifc1.cin = i[0];
            @(negedge clk);
            ifc1.start = 1'b0;
            bn = 0;
            w = 0;
            while (ifc1.done !== 1'b1 && w < 10) begin
                if (ifc1.busy === 1'b1) bn++;
                @(negedge clk);
                w++;
            end
            check($sformatf("w1 sweep %0d busy", i), bn, 1);
            check($sformatf("w1 sweep %0d result", i), {ifc1.cout, ifc1.sum}, exp2);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_core.md
Name: serial_adder_core

Overview:
- Parametrised multi-cycle adder/subtractor/accumulator; successor to the single-cycle full adder.
- Processes DIGIT bits per clock from the LSB upward with a registered carry between digits, so one result takes WIDTH/DIGIT cycles.
- Adds start/busy/done handshake, subtract and accumulate modes, and a signed-overflow flag.
- Sits behind the Tiny Tapeout wrapper; ui_in/uio_in carry operands and control, uo_out carries the result.

Parameters:
- WIDTH, 8, operand and result width in bits.
- DIGIT, 2, bits processed per cycle. WIDTH must be an integer multiple of DIGIT; otherwise elaboration fails.
- STEPS (localparam) = WIDTH/DIGIT.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  clock enable; when low, all state holds
- start  in  1  request; sampled only in IDLE or DONE
- mode  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (ignored in ACC and CLR)
- cin  in  1  carry-in (ADD, ACC only)
- busy  out  1  high while a computation is in progress
- done  out  1  one-cycle pulse: result valid
- sum  out  WIDTH  result register
- cout  out  1  carry-out (SUB: 1 = no borrow)
- ovf  out  1  signed overflow

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal accumulator, shift registers and carry cleared. Reset mid-computation aborts it with no done pulse.
- ena=0: no state, counter, output or carry changes. done stays at its current value and stretches until ena returns.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1 and ena=1 (edge k): latch operands into shift registers.
  - ADD: X=a, Y=b, carry=cin.
  - SUB: X=a, Y=~b, carry=1.
  - ACC: X=accumulator, Y=a, carry=cin.
  - CLR: sum, accumulator, cout and ovf cleared at edge k; go to DONE (done=1 for one cycle); no RUN.
  - Other modes: step counter=0; go to RUN.
- RUN: each enabled edge adds the low DIGIT bits of X, Y and carry, shifts the partial result in from the MSB side, updates carry, and increments the counter.
  - busy=1 for exactly STEPS enabled cycles (edges k+1..k+STEPS).
  - At edge k+STEPS: write sum, cout = final carry, ovf = carry-into-MSB XOR carry-out; ACC also copies sum into the accumulator. Then state=DONE, busy=0, done=1.
- sum/cout/ovf hold their previous result during RUN and change only at completion or CLR.
- DONE lasts one cycle, then IDLE. start sampled in DONE launches the next operation with no idle cycle (back-to-back).
- start while in RUN is ignored, with no queuing. mode, a, b and cin are sampled only at the start edge; later changes have no effect.
- Arithmetic is modulo 2^WIDTH. In SUB, cout=0 means a<b unsigned.
- Accumulator persists across ADD/SUB operations. Only ACC completion, CLR or reset changes it.

Test Plan:
- WIDTH=8, DIGIT=2, ADD a=0x5A, b=0x33, cin=1: busy high 4 cycles, then done one cycle with sum=0x8E, cout=0, ovf=1.
- SUB a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0. SUB a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- CLR (done 1 cycle after start, sum=0x00), then ACC a=0xFF, cin=0 -> 0xFF, then ACC a=0x02 -> sum=0x01, cout=1, ovf=0.
- start pulsed mid-RUN is ignored (result unchanged, exactly one done). start asserted in the DONE cycle begins the next op: busy rises next cycle.
- ena low for 3 cycles mid-RUN: done arrives 3 cycles later, same sum. rst_n pulsed mid-RUN: all outputs 0 immediately, no done, and a following ADD 0x01+0x01 gives 0x02.
- WIDTH=1, DIGIT=1 sweep of all 8 {a,b,cin} combinations: {cout,sum} equals a+b+cin, each with a 1-cycle busy.
